// File: rtl/pdm_capture.sv
// PDM microphone capture: divides the system clock into a PDM clock, samples one or
// two channels on opposite PDM clock phases, packs samples MSB-first into words and
// queues completed words in a small FIFO with a sticky overrun flag.
module pdm_capture #(
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned CLK_DIV    = 100,
    parameter int unsigned STEREO     = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              chan_sel,
    input  logic              data_in,
    output logic              pdm_clk_o,
    output logic              pdm_irsel_o,
    output logic [WORD_W-1:0] data,
    output logic              data_chan,
    output logic              valid,
    input  logic              ready,
    output logic              overrun,
    input  logic              clear_overrun
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam int unsigned BC_W  = $clog2(WORD_W);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_CH0   = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [BC_W-1:0]  BC_LAST   = BC_W'(WORD_W - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic               w_run;
    logic               r_sel;
    logic [CNT_W-1:0]   r_cnt;

    // Only WORD_W-1 bits need storing; the final sample completes the word on the fly.
    logic [WORD_W-2:0]  r_sh [2];
    logic [BC_W-1:0]    r_bc [2];
    logic [WORD_W-1:0]  w_shift [2];
    logic [1:0]         w_samp;
    logic [1:0]         w_done;

    logic               w_push;
    logic               w_push_chan;
    logic [WORD_W-1:0]  w_push_word;

    logic [WORD_W:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]        r_wptr;
    logic [AW:0]        r_rptr;
    logic [WORD_W:0]    w_head;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_wr;
    logic               w_drop;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic: enable alone moves between IDLE and RUN.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (enable)  w_state_d = StRun;
            StRun:   if (!enable) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // FSM-derived outputs: microphone clock and channel strap.
    always_comb begin
        w_run       = (r_state == StRun);
        pdm_clk_o   = w_run && (r_cnt < CNT_HALF);
        pdm_irsel_o = (STEREO != 0) ? 1'b0 : r_sel;
    end

    // Channel select is captured only on the IDLE->RUN transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sel <= 1'b0;
        end else if (r_state == StIdle && enable) begin
            r_sel <= chan_sel;
        end
    end

    // Divider counter; forced to 0 whenever the next cycle is not a RUN cycle.
    always_ff @(posedge clock) begin
        if (reset || !(w_run && enable)) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Sample strobes and word completion per channel; channels never strobe together.
    always_comb begin
        w_samp[0] = w_run && (r_cnt == CNT_CH0)  && ((STEREO != 0) || !r_sel);
        w_samp[1] = w_run && (r_cnt == CNT_LAST) && ((STEREO != 0) || r_sel);
        for (int c = 0; c < 2; c++) begin
            w_shift[c] = {r_sh[c], data_in};
            w_done[c]  = w_samp[c] && (r_bc[c] == BC_LAST);
        end
        w_push      = |w_done;
        w_push_chan = w_done[1];
        w_push_word = w_done[1] ? w_shift[1] : w_shift[0];
    end

    // Shift registers and bit counters; any exit from RUN discards the partial word.
    always_ff @(posedge clock) begin
        for (int c = 0; c < 2; c++) begin
            if (reset || !(w_run && enable)) begin
                r_sh[c] <= '0;
                r_bc[c] <= '0;
            end else if (w_samp[c]) begin
                r_sh[c] <= w_shift[c][WORD_W-2:0];
                r_bc[c] <= w_done[c] ? '0 : r_bc[c] + 1'b1;
            end
        end
    end

    // FIFO status and handshake; a pop frees the slot for a same-cycle push.
    always_comb begin
        w_empty = (r_wptr == r_rptr);
        w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
        w_pop   = !w_empty && ready;
        w_wr    = w_push && (!w_full || w_pop);
        w_drop  = w_push && w_full && !w_pop;
        w_head  = r_mem[r_rptr[AW-1:0]];
        valid     = !w_empty;
        data      = w_empty ? '0 : w_head[WORD_W-1:0];
        data_chan = !w_empty && w_head[WORD_W];
    end

    // FIFO storage; stale entries are never visible since outputs are gated by empty.
    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= {w_push_chan, w_push_word};
        end
    end

    // FIFO pointers and sticky overrun; a drop beats a simultaneous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_drop) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pdm_capture.sv
// Bench for pdm_capture: a mono and a stereo instance share all inputs. A cycle-level
// reference model predicts queued words and flags; a monitor compares at negedges.
module tb_pdm_capture;

    localparam int W     = 8;
    localparam int DIV   = 4;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    logic chan_sel = 1'b0;
    logic data_in = 1'b0;
    logic ready = 1'b1;
    logic clear_overrun = 1'b0;

    logic [W-1:0] o_data [2];
    logic         o_chan [2];
    logic         o_valid [2];
    logic         o_ovr [2];
    logic         o_pclk [2];
    logic         o_irsel [2];

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit           m_run = 0;
    int           m_t = 0;
    bit           m_sel = 0;
    logic [W-1:0] m_bits [2][2];
    int           m_nb [2][2];
    int           m_occ [2];
    bit           m_ovr [2];
    logic [W:0]   exp_q [2][$];

    logic [W-1:0] last_word [2];
    logic         last_chan [2];
    int           pops [2];

    always #5 clock = ~clock;

    pdm_capture #(.WORD_W(W), .CLK_DIV(DIV), .STEREO(0), .FIFO_DEPTH(DEPTH)) u_mono (
        .clock(clock), .reset(reset), .enable(enable), .chan_sel(chan_sel),
        .data_in(data_in), .pdm_clk_o(o_pclk[0]), .pdm_irsel_o(o_irsel[0]),
        .data(o_data[0]), .data_chan(o_chan[0]), .valid(o_valid[0]), .ready(ready),
        .overrun(o_ovr[0]), .clear_overrun(clear_overrun)
    );

    pdm_capture #(.WORD_W(W), .CLK_DIV(DIV), .STEREO(1), .FIFO_DEPTH(DEPTH)) u_stereo (
        .clock(clock), .reset(reset), .enable(enable), .chan_sel(chan_sel),
        .data_in(data_in), .pdm_clk_o(o_pclk[1]), .pdm_irsel_o(o_irsel[1]),
        .data(o_data[1]), .data_chan(o_chan[1]), .valid(o_valid[1]), .ready(ready),
        .overrun(o_ovr[1]), .clear_overrun(clear_overrun)
    );

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d at %0t: got %0h, expected %0h", name, inst, $time, act,
                     exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_bits();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                m_bits[i][c] = '0;
                m_nb[i][c]   = 0;
            end
        end
    endtask

    // Reference model: RUN-time t drives sample points; FIFO tracked as an occupancy count.
    initial begin
        bit         pop;
        bit         push;
        bit         drop;
        bit         active;
        int         pt;
        logic [W:0] w;
        clear_bits();
        for (int i = 0; i < 2; i++) begin
            m_occ[i] = 0;
            m_ovr[i] = 0;
        end
        forever begin
            @(posedge clock);
            if (reset) begin
                m_run = 0;
                m_t   = 0;
                m_sel = 0;
                clear_bits();
                for (int i = 0; i < 2; i++) begin
                    m_occ[i] = 0;
                    m_ovr[i] = 0;
                    exp_q[i].delete();
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    pop  = (m_occ[i] > 0) && ready;
                    push = 0;
                    w    = '0;
                    if (m_run) begin
                        for (int c = 0; c < 2; c++) begin
                            active = (i == 1) || (c == int'(m_sel));
                            pt     = (c == 0) ? DIV / 2 - 1 : DIV - 1;
                            if (active && (m_t % DIV) == pt) begin
                                m_bits[i][c] = {m_bits[i][c][W-2:0], data_in};
                                m_nb[i][c]++;
                                if (m_nb[i][c] == W) begin
                                    push = 1;
                                    w    = {(c == 1), m_bits[i][c]};
                                    m_nb[i][c] = 0;
                                end
                            end
                        end
                    end
                    drop = push && (m_occ[i] == DEPTH) && !pop;
                    if (push && !drop) begin
                        exp_q[i].push_back(w);
                        m_occ[i]++;
                    end
                    if (pop) m_occ[i]--;
                    if (drop) m_ovr[i] = 1;
                    else if (clear_overrun) m_ovr[i] = 0;
                end
                if (m_run) begin
                    m_t++;
                    if (!enable) begin
                        m_run = 0;
                        clear_bits();
                    end
                end else if (enable) begin
                    m_run = 1;
                    m_t   = 0;
                    m_sel = chan_sel;
                    clear_bits();
                end
            end
        end
    end

    // Monitor: flags every cycle, head word against the scoreboard on each handshake.
    initial begin
        logic [W:0] w;
        for (int i = 0; i < 2; i++) pops[i] = 0;
        forever begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                chk("valid", i, 32'(o_valid[i]), 32'(m_occ[i] > 0));
                chk("overrun", i, 32'(o_ovr[i]), 32'(m_ovr[i]));
                chk("pdm_clk", i, 32'(o_pclk[i]), 32'(m_run && ((m_t % DIV) < DIV / 2)));
                chk("irsel", i, 32'(o_irsel[i]), 32'((i == 0) ? m_sel : 1'b0));
                if (o_valid[i] === 1'b1 && ready) begin
                    if (exp_q[i].size() == 0) begin
                        chk("unexpected_word", i, 32'(o_data[i]), 32'hFFFF_FFFF);
                    end else begin
                        w = exp_q[i].pop_front();
                        chk("data", i, 32'(o_data[i]), 32'(w[W-1:0]));
                        chk("data_chan", i, 32'(o_chan[i]), 32'(w[W]));
                        last_word[i] = o_data[i];
                        last_chan[i] = o_chan[i];
                        pops[i]++;
                    end
                end
            end
        end
    end

    // Stimulus.
    initial begin
        logic [7:0] pat;
        int         p0;
        int         p1;
        pat = 8'b1010_0101;

        // Reset held with enable and ready high.
        cyc(3);
        for (int i = 0; i < 2; i++) begin
            chk("rst_data", i, 32'(o_data[i]), 32'h0);
            chk("rst_chan", i, 32'(o_chan[i]), 32'h0);
        end
        reset  = 1'b0;
        enable = 1'b0;
        cyc(3);

        // Mono channel 0, bit pattern A5 held over whole PDM periods.
        chan_sel = 1'b0;
        enable   = 1'b1;
        cyc(1);
        p0 = pops[0];
        for (int b = 7; b >= 0; b--) begin
            data_in = pat[b];
            cyc(4);
        end
        chk("mono_A5", 0, 32'(last_word[0]), 32'hA5);
        chk("mono_pops", 0, 32'(pops[0] - p0), 32'd1);
        enable = 1'b0;
        cyc(3);

        // Stereo: 1 in the high phase, 0 in the low phase.
        enable = 1'b1;
        cyc(1);
        for (int k = 0; k < 64; k++) begin
            data_in = ((k % 4) < 2);
            cyc(1);
        end
        cyc(2);
        chk("stereo_last_word", 1, 32'(last_word[1]), 32'h00);
        chk("stereo_last_chan", 1, 32'(last_chan[1]), 32'h1);
        chk("mono_ff", 0, 32'(last_word[0]), 32'hFF);
        enable = 1'b0;
        cyc(3);

        // Overrun with the consumer stalled, then clear and drain.
        ready  = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 100; k++) begin
            data_in = 1'($urandom);
            cyc(1);
        end
        enable = 1'b0;
        cyc(2);
        chk("overrun_set", 1, 32'(o_ovr[1]), 32'h1);
        chk("no_overrun_mono", 0, 32'(o_ovr[0]), 32'h0);
        clear_overrun = 1'b1;
        cyc(1);
        clear_overrun = 1'b0;
        chk("overrun_clr", 1, 32'(o_ovr[1]), 32'h0);
        p0    = pops[0];
        p1    = pops[1];
        ready = 1'b1;
        cyc(10);
        chk("drain_stereo", 1, 32'(pops[1] - p1), 32'd4);
        chk("drain_mono", 0, 32'(pops[0] - p0), 32'd3);

        // Partial word abandoned by enable, then a fresh word on mono channel 1.
        chan_sel = 1'b1;
        enable   = 1'b1;
        cyc(1);
        chan_sel = 1'b0;
        for (int k = 0; k < 12; k++) begin
            data_in = 1'($urandom);
            cyc(1);
        end
        enable = 1'b0;
        cyc(3);
        chk("idle_pclk", 0, 32'(o_pclk[0]), 32'h0);
        chk("idle_irsel", 0, 32'(o_irsel[0]), 32'h1);
        enable = 1'b1;
        for (int k = 0; k < 40; k++) begin
            data_in = 1'($urandom);
            cyc(1);
        end

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            data_in       = 1'($urandom);
            ready         = ($urandom_range(0, 9) < 6);
            clear_overrun = ($urandom_range(0, 19) == 0);
            chan_sel      = 1'($urandom);
            if ($urandom_range(0, 99) < 2) enable = ~enable;
            reset         = ($urandom_range(0, 299) == 0);
            cyc(1);
        end
        reset         = 1'b0;
        clear_overrun = 1'b0;
        enable        = 1'b0;
        ready         = 1'b1;
        cyc(10);

        // Reset with two words queued and a pop pending.
        ready  = 1'b0;
        enable = 1'b1;
        cyc(34);
        chk("queued_valid", 1, 32'(o_valid[1]), 32'h1);
        ready = 1'b1;
        reset = 1'b1;
        cyc(1);
        for (int i = 0; i < 2; i++) begin
            chk("rst_valid", i, 32'(o_valid[i]), 32'h0);
            chk("rst_ovr", i, 32'(o_ovr[i]), 32'h0);
        end
        reset = 1'b0;
        cyc(5);
        enable = 1'b0;
        cyc(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pdm_capture.md
PDM_CAPTURE -- requirements
Module: pdm_capture

Interface
REQ-001 Parameter WORD_W, default 16, meaning output word width in PDM samples; legal range 2..32.
REQ-002 Parameter CLK_DIV, default 100, meaning system clocks per PDM clock period (100 MHz -> 1 MHz); SHALL be even and >= 4.
REQ-003 Parameter STEREO, default 0, meaning 0 = mono (one channel chosen by chan_sel), 1 = both channels captured.
REQ-004 Parameter FIFO_DEPTH, default 4, meaning output word buffer entries; SHALL be a power of 2, >= 2.
REQ-005 clock  input  1  system clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  capture enable; low = IDLE.
REQ-008 chan_sel  input  1  mono-mode channel select; ignored when STEREO=1.
REQ-009 data_in  input  1  PDM data line from microphone(s).
REQ-010 pdm_clk_o  output  1  divided microphone clock.
REQ-011 pdm_irsel_o  output  1  microphone channel-select strap.
REQ-012 data  output  WORD_W  head-of-FIFO word.
REQ-013 data_chan  output  1  channel tag of head word (0 = high-phase channel, 1 = low-phase channel).
REQ-014 valid  output  1  FIFO non-empty; data/data_chan meaningful.
REQ-015 ready  input  1  consumer accepts head word when valid & ready.
REQ-016 overrun  output  1  sticky flag: a completed word was dropped.
REQ-017 clear_overrun  input  1  clears overrun.

Function
REQ-018 States IDLE and RUN; IDLE->RUN when enable=1; RUN->IDLE when enable=0; reset forces IDLE.
REQ-019 IDLE: divider cnt held 0, pdm_clk_o=0, both shift registers and both bit counters cleared; FIFO keeps contents and continues to drain.
REQ-020 On IDLE->RUN, chan_sel SHALL be latched into sel_q; chan_sel changes during RUN have no effect.
REQ-021 pdm_irsel_o SHALL equal sel_q when STEREO=0 and 0 when STEREO=1; reset value 0.
REQ-022 RUN: cnt counts 0..CLK_DIV-1 and wraps to 0; pdm_clk_o=1 in cycles where cnt < CLK_DIV/2, else 0.
REQ-023 Channel 0 SHALL sample data_in in the cycle cnt = CLK_DIV/2-1; channel 1 in the cycle cnt = CLK_DIV-1.
REQ-024 STEREO=0: only channel sel_q samples; STEREO=1: both sample, each with its own shift register and bit counter.
REQ-025 Shift MSB-first: sample enters bit 0, prior bits shift up; first sample of a word ends in bit WORD_W-1.
REQ-026 On a channel's WORD_W-th sample, the complete word (including that sample) and its channel tag SHALL be pushed to the FIFO in that same cycle; the bit counter returns to 0 with no gap.
REQ-027 valid SHALL assert the cycle after a push into an empty FIFO (1-cycle latency from final sample).
REQ-028 Pop when valid & ready; next entry (if any) presented the following cycle, order preserved.
REQ-029 Push while full and no pop in the same cycle: word dropped, FIFO unchanged, overrun set next cycle.
REQ-030 Push while full with a pop in the same cycle: push accepted, no overrun.
REQ-031 clear_overrun=1 clears overrun next cycle; a simultaneous drop wins (overrun stays 1).
REQ-032 enable falling mid-word discards the partial word; no push occurs.

Reset
REQ-033 reset=1 SHALL, at the next edge: empty FIFO, valid=0, data=0, data_chan=0, overrun=0, pdm_clk_o=0, pdm_irsel_o=0, state IDLE, cnt and counters 0; reset overrides enable, ready and clear_overrun; reset mid-word or with FIFO non-empty discards everything.

Verification (bench uses WORD_W=8, CLK_DIV=4, FIFO_DEPTH=4)
REQ-034 Reset with enable=1, ready=1 -> all outputs 0 during and one cycle after reset.
REQ-035 STEREO=0, chan_sel=0, data_in driven 1,0,1,0,0,1,0,1 at channel-0 sample points -> data=0xA5, data_chan=0, valid 1 for one cycle with ready=1, 32 cycles per word.
REQ-036 STEREO=1, data_in=1 at channel-0 and 0 at channel-1 sample points -> alternating words 0xFF tag 0, 0x00 tag 1, 2 cycles apart.
REQ-037 ready=0, STEREO=1 -> first 4 words held, 5th dropped, overrun=1; clear_overrun pulse clears it; draining yields 4 words in capture order.
REQ-038 enable low after 3 samples, then high -> pdm_clk_o=0 in IDLE, no push; next word built from 8 fresh samples.
REQ-039 reset asserted with 2 words queued and pop active -> valid=0 next cycle, no further pops, overrun=0.
